// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache: read hits answer in the request cycle,
// misses refill a line one word per memory beat; every memory beat may stall indefinitely on dmem_ready_i.
module data_cache #(
   parameter int DWidth       = 32,
   parameter int NumLines     = 16,
   parameter int WordsPerLine = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              write_i,
   input  logic [DWidth-1:0] addr_i,
   input  logic [DWidth-1:0] wdata_i,
   output logic [DWidth-1:0] rdata_o,
   output logic              ready_o,
   input  logic              dmem_ready_i,
   input  logic [DWidth-1:0] dmem_rdata_i,
   output logic [DWidth-1:0] dmem_wdata_o,
   output logic [DWidth-1:0] dmem_addr_o,
   output logic              dmem_req_o,
   output logic              dmem_write_o
);

   localparam int OffW = $clog2(WordsPerLine);
   localparam int IdxW = $clog2(NumLines);
   localparam int O    = OffW + 2;
   localparam int TagW = DWidth - O - IdxW;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

   state_e              state_q;
   logic [OffW-1:0]     beat_q;
   logic [DWidth-O-1:0] line_q;
   logic [NumLines-1:0] valid_q;
   logic [TagW-1:0]     tag_q  [NumLines];
   logic [DWidth-1:0]   data_q [NumLines*WordsPerLine];

   logic [OffW-1:0] off;
   logic [IdxW-1:0] idx;
   logic [TagW-1:0] tag;
   logic [IdxW-1:0] rf_idx;
   logic            hit;
   logic            unused_lsb;

   assign off        = addr_i[O-1:2];
   assign idx        = addr_i[O+IdxW-1:O];
   assign tag        = addr_i[DWidth-1:O+IdxW];
   assign hit        = req_i & valid_q[idx] & (tag_q[idx] == tag);
   assign rf_idx     = line_q[IdxW-1:0];
   assign unused_lsb = ^addr_i[1:0];

   always_comb begin
      ready_o      = 1'b0;
      rdata_o      = '0;
      dmem_req_o   = 1'b0;
      dmem_write_o = 1'b0;
      dmem_addr_o  = '0;
      dmem_wdata_o = '0;
      unique case (state_q)
         IDLE: begin
            if (hit && !write_i) begin
               ready_o = 1'b1;
               rdata_o = data_q[{idx, off}];
            end
         end
         REFILL: begin
            dmem_req_o  = 1'b1;
            dmem_addr_o = {line_q, beat_q, 2'b00};
         end
         WRITE: begin
            dmem_req_o   = 1'b1;
            dmem_write_o = 1'b1;
            dmem_addr_o  = {addr_i[DWidth-1:2], 2'b00};
            dmem_wdata_o = wdata_i;
            ready_o      = dmem_ready_i;
         end
         default: ;
      endcase
   end

   // The refill line is latched at the miss so a dropped request still completes a coherent line.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         beat_q  <= '0;
         valid_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_i) begin
                  if (write_i) begin
                     state_q <= WRITE;
                  end else if (!hit) begin
                     state_q      <= REFILL;
                     beat_q       <= '0;
                     line_q       <= addr_i[DWidth-1:O];
                     valid_q[idx] <= 1'b0;
                  end
               end
            end
            REFILL: begin
               if (dmem_ready_i) begin
                  data_q[{rf_idx, beat_q}] <= dmem_rdata_i;
                  beat_q                   <= beat_q + OffW'(1);
                  if (beat_q == OffW'(WordsPerLine - 1)) begin
                     tag_q[rf_idx]   <= line_q[DWidth-O-1:IdxW];
                     valid_q[rf_idx] <= 1'b1;
                     state_q         <= IDLE;
                  end
               end
            end
            WRITE: begin
               if (dmem_ready_i) begin
                  if (hit) begin
                     data_q[{idx, off}] <= wdata_i;
                  end
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: a line-level cache model plus a sparse memory model predict
// every load value, memory transfer list and (for fixed memory latency) the completion cycle.
module tb_data_cache;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i;
   logic        write_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        ready_o;
   logic        dmem_ready_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_addr_o;
   logic        dmem_req_o;
   logic        dmem_write_o;

   always #5 clk_i = ~clk_i;

   data_cache dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .write_i      (write_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .ready_o      (ready_o),
      .dmem_ready_i (dmem_ready_i),
      .dmem_rdata_i (dmem_rdata_i),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_req_o   (dmem_req_o),
      .dmem_write_o (dmem_write_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wd;
   } txn_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat_mode = 1;       // <0: random 0..2 wait cycles per beat
   logic [31:0] stall_addr = 32'hFFFF_FFFF;
   int          stall_n  = 0;
   int          stall_obs = 0;
   txn_t        txn_q[$];
   logic [31:0] mem_w [logic [31:0]];

   // Cache model: one entry per line, indexed by address bits [7:4]
   bit          mv [16];
   logic [23:0] mt [16];
   logic [31:0] md [16][4];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_w.exists(a)) return mem_w[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   // Memory responder: decides dmem_ready_i once per cycle after outputs settle.
   initial begin
      int wait_left;
      bit pending;
      wait_left    = 0;
      pending      = 0;
      dmem_ready_i = 1'b0;
      dmem_rdata_i = '0;
      forever begin
         @(posedge clk_i);
         #2;
         dmem_ready_i = 1'b0;
         dmem_rdata_i = '0;
         if (dmem_req_o === 1'b1) begin
            if (!pending) begin
               pending   = 1;
               wait_left = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
               if (stall_n > 0 && dmem_addr_o == stall_addr) begin
                  wait_left = stall_n;
                  stall_n   = 0;
               end
            end
            if (wait_left == 0) begin
               dmem_ready_i = 1'b1;
               dmem_rdata_i = dmem_write_o ? 32'h0 : mem_val(dmem_addr_o);
               pending      = 0;
            end else begin
               wait_left--;
            end
         end else begin
            pending = 0;
         end
      end
   end

   // Monitor: logs completed beats, applies stores, and checks request stability while stalled.
   initial begin
      bit          prev_hold;
      bit          prev_rst;
      logic [31:0] prev_addr;
      logic [31:0] prev_wd;
      logic        prev_wr;
      prev_hold = 0;
      prev_rst  = 0;
      prev_addr = '0;
      prev_wd   = '0;
      prev_wr   = 1'b0;
      forever begin
         @(negedge clk_i);
         if (prev_hold && prev_rst) begin
            check_val("hold_req", {31'd0, dmem_req_o}, 32'd1);
            check_val("hold_addr", dmem_addr_o, prev_addr);
            check_val("hold_wr", {31'd0, dmem_write_o}, {31'd0, prev_wr});
            check_val("hold_wdata", dmem_wdata_o, prev_wd);
         end
         prev_hold = (dmem_req_o === 1'b1) && (dmem_ready_i === 1'b0);
         prev_rst  = (rst_ni === 1'b1);
         prev_addr = dmem_addr_o;
         prev_wd   = dmem_wdata_o;
         prev_wr   = dmem_write_o;
         if (prev_hold && dmem_addr_o == stall_addr) stall_obs++;
         if (dmem_req_o === 1'b1 && dmem_ready_i === 1'b1) begin
            txn_q.push_back('{addr: dmem_addr_o, wr: dmem_write_o, wd: dmem_wdata_o});
            if (dmem_write_o) mem_w[dmem_addr_o] = dmem_wdata_o;
         end
      end
   end

   // One core access, checked against the model; stall_extra is any injected memory stall.
   task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd, input int stall_extra);
      int          idx;
      int          w;
      int          cyc;
      int          exp_cyc;
      bit          hit;
      bit          rdy;
      bit          req_at_rdy;
      logic [23:0] tg;
      logic [31:0] base;
      logic [31:0] got_rd;
      logic [31:0] exp_rd;
      txn_t        exp_q[$];
      idx    = int'(a[7:4]);
      w      = int'(a[3:2]);
      tg     = a[31:8];
      base   = {a[31:4], 4'h0};
      hit    = mv[idx] && (mt[idx] == tg);
      exp_rd = '0;
      if (wr) begin
         exp_q.push_back('{addr: {a[31:2], 2'b00}, wr: 1'b1, wd: wd});
         exp_cyc = 2 + lat_mode + stall_extra;
         if (hit) md[idx][w] = wd;
      end else if (hit) begin
         exp_cyc = 1;
         exp_rd  = md[idx][w];
      end else begin
         for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{addr: base + 32'(4 * i), wr: 1'b0, wd: 32'h0});
            md[idx][i] = mem_val(base + 32'(4 * i));
         end
         mv[idx] = 1;
         mt[idx] = tg;
         exp_rd  = md[idx][w];
         exp_cyc = 2 + 4 * (lat_mode + 1) + stall_extra;
      end

      @(posedge clk_i);
      #1;
      txn_q.delete();
      req_i   = 1'b1;
      write_i = wr;
      addr_i  = a;
      wdata_i = wd;
      cyc     = 0;
      rdy     = 0;
      while (!rdy && cyc < 400) begin
         @(negedge clk_i);
         cyc++;
         rdy = (ready_o === 1'b1);
      end
      got_rd     = rdata_o;
      req_at_rdy = (dmem_req_o === 1'b1);
      #1;
      check_val("ready", {31'd0, rdy}, 32'd1);
      if (!wr) check_val("rdata", got_rd, exp_rd);
      if (!wr && hit) begin
         check_val("hit_cycles", 32'(cyc), 32'd1);
         check_val("hit_no_req", {31'd0, req_at_rdy}, 32'd0);
      end else if (lat_mode >= 0) begin
         check_val("cycles", 32'(cyc), 32'(exp_cyc));
      end
      check_val("txn_count", 32'(txn_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++) begin
         check_val("txn_addr", txn_q[i].addr, exp_q[i].addr);
         check_val("txn_wr", {31'd0, txn_q[i].wr}, {31'd0, exp_q[i].wr});
         if (exp_q[i].wr) check_val("txn_wdata", txn_q[i].wd, exp_q[i].wd);
      end
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      logic [31:0] a;
      logic [31:0] tags [4];
      tags[0] = 32'h0;
      tags[1] = 32'h1;
      tags[2] = 32'h11;
      tags[3] = 32'hABCDEF;
      for (int i = 0; i < 16; i++) mv[i] = 0;
      rst_ni  = 1'b0;
      req_i   = 1'b0;
      write_i = 1'b0;
      addr_i  = '0;
      wdata_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_val("rst_ready", {31'd0, ready_o}, 32'd0);
      check_val("rst_req", {31'd0, dmem_req_o}, 32'd0);
      check_val("rst_wr", {31'd0, dmem_write_o}, 32'd0);
      check_val("rst_rdata", rdata_o, 32'd0);
      check_val("rst_addr", dmem_addr_o, 32'd0);
      check_val("rst_wdata", dmem_wdata_o, 32'd0);

      // Cold miss, hit follow-up, write hit, write miss with later refill
      lat_mode = 1;
      access(0, 32'h104, 0, 0);
      access(0, 32'h10C, 0, 0);
      access(1, 32'h104, 32'hDEADBEEF, 0);
      access(0, 32'h104, 0, 0);
      check_val("write_hit_data", md[0][1], 32'hDEADBEEF);
      lat_mode = 0;
      access(1, 32'h2000, 32'h12345678, 0);
      access(0, 32'h2000, 0, 0);

      // Conflict on index 0
      access(0, 32'h104, 0, 0);
      access(0, 32'h1104, 0, 0);
      access(0, 32'h104, 0, 0);

      // Five-cycle stall on refill beat 2
      access(0, 32'h1104, 0, 0);
      stall_addr = 32'h108;
      stall_n    = 5;
      stall_obs  = 0;
      access(0, 32'h104, 0, 5);
      check_val("stall_cycles", 32'(stall_obs), 32'd5);

      // Reset after beat 1 of a refill
      access(0, 32'h1104, 0, 0);
      @(posedge clk_i);
      #1;
      txn_q.delete();
      req_i   = 1'b1;
      write_i = 1'b0;
      addr_i  = 32'h104;
      cyc     = 0;
      while (txn_q.size() < 2 && cyc < 100) begin
         @(negedge clk_i);
         #1;
         cyc++;
      end
      check_val("rst_mid_beats", 32'(txn_q.size()), 32'd2);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      req_i  = 1'b0;
      @(negedge clk_i);
      check_val("rst_mid_req", {31'd0, dmem_req_o}, 32'd0);
      check_val("rst_mid_ready", {31'd0, ready_o}, 32'd0);
      for (int i = 0; i < 16; i++) mv[i] = 0;
      access(0, 32'h104, 0, 0);

      // Random traffic with random memory latency
      lat_mode = -1;
      for (int n = 0; n < 300; n++) begin
         a = (tags[$urandom_range(0, 3)] << 8) | (32'($urandom_range(0, 3)) << 4)
             | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         access($urandom_range(0, 9) < 4, a, $urandom, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
